flow_tick_multi_gen: RTL
========================

// Module: flow_tick_multi_gen
// PURPOSE
//  Multi-channel programmable tick generator for rx-port flow control. A shared ms prescaler
//  drives CH_NUM independent channels. Each channel emits a valid/ready-handshaked pulse
//  every programmed number of ms and counts ticks lost while a pulse is still unaccepted.
//  Feeds per-port rate/credit refresh logic in rx_port_mng flow_ctrl.
// PARAMETERS
//  CLOCK_PERIOD  100_000_000  clock frequency in Hz; MS_CNT = CLOCK_PERIOD/1000
//  SIM_MODE      "TRUE"       "TRUE": MS_CNT = 30 clocks per ms (fast sim)
//  CH_NUM        4            number of channels, 1..16
//  PERIOD_W      16           width of per-channel period in ms
//  MISS_W        8            width of per-channel saturating missed-tick counter
// PORTS
//  i_tick_clk     in   1               clock
//  i_tick_rst_n   in   1               async reset, active low
//  i_ch_en        in   CH_NUM          per-channel run enable, level
//  i_period       in   CH_NUM*PERIOD_W period in ms, channel c = [c*PERIOD_W +: PERIOD_W]
//  i_phase        in   CH_NUM*PERIOD_W first-pulse phase offset in ms (FLOW_TICK_PHASE_EN only)
//  o_tick_valid   out  CH_NUM          pulse pending, held until accepted
//  i_tick_ready   in   CH_NUM          consumer accept
//  i_miss_clr     in   CH_NUM          clear missed counter, 1-cycle pulse
//  o_miss_cnt     out  CH_NUM*MISS_W   missed ticks, channel c = [c*MISS_W +: MISS_W]
// BEHAVIOUR
//  - Reset: all outputs 0, prescaler 0, channel counters 0, latched periods 1.
//  - Enable edge: registered copy of i_ch_en; rise = i_ch_en & ~registered, fall = inverse.
//  - Prescaler: 0..MS_CNT-1, wraps. Held at 0 while no channel enabled. Loaded 0 at an edge
//    where a channel rises and no other channel is enabled. ms_tick = (prescaler==MS_CNT-1).
//  - Channel rise: cnt<=0 (phase variant below); period latched from i_period; 0 -> 1.
//  - Running, ms_tick: if cnt==period-1 -> cnt<=0, fire, re-latch i_period (changes take
//    effect only at wrap); else cnt<=cnt+1. No ms_tick: hold.
//  - Joining while another channel runs: aligns to the shared prescaler.
//    First interval is (period-1, period] ms.
//  - Latency: o_tick_valid rises at the edge consuming the final ms_tick.
//    Single channel, SIM_MODE: period*30 clocks after the edge first sampling i_ch_en high.
//  - Handshake, per channel, priority order:
//    fall -> valid<=0;
//    fire & (~valid | ready) -> valid<=1;
//    fire & valid & ~ready -> valid stays 1, miss+1;
//    ready -> valid<=0.
//    Ready while valid=0 is ignored.
//  - Missed counter saturates at all-ones. Clear wins over a same-cycle increment (result 0).
//    Not cleared by disable.
//  - Disable: cnt<=0, valid<=0, pending pulse dropped. Re-enable restarts as a fresh rise.
//  - Channels are fully independent except for the shared prescaler.
//    Rise of one channel never disturbs running channels.
// CONFIGURATION
//  FLOW_TICK_PHASE_EN defined: i_phase present. At rise, cnt <= min(phase, period-1), so the
//   first pulse comes (period-phase) ms after enable; later pulses at the full period.
//  Undefined: i_phase port absent, cnt loads 0 at rise, all channels start in phase.
// TESTING  (SIM_MODE="TRUE", CH_NUM=4, MS_CNT=30)
//  1 ch0 period=3, enable, ready tied 1 -> valid pulses 1 cycle at +90, +180, +270; miss stays 0.
//  2 ch1 period=2, ready held 0 for 200 cycles -> valid high from +60;
//    miss=1 at +120, =2 at +180; ready -> valid falls next edge.
//  3 MISS_W=2, ready held 0 for 10 periods -> miss saturates at 3.
//    miss_clr coincident with a fire -> miss=0.
//  4 ch0 running period=3, i_period->5 mid-interval -> next pulse still at 3 ms, following at +5 ms.
//    period=0 -> pulse every 1 ms.
//  5 disable ch2 with valid pending -> valid 0 next edge.
//    Re-enable while ch0 runs -> first ch2 pulse within (period-1, period] ms.
//    Async reset mid-count -> all outputs 0 immediately.
//  6 FLOW_TICK_PHASE_EN, period=4, phase=1 -> first pulse +90, then +210;
//    phase=9 clamps -> first pulse +30.

Source files
------------

// File: rtl/flow_tick_multi_gen.sv
// -----------------------------------------------------------------------------
// flow_tick_multi_gen
//   Multi-channel programmable tick generator for rx-port flow control.
//   A shared millisecond prescaler drives CH_NUM independent channels. Each
//   channel raises a valid/ready-handshaked pulse every programmed number of ms
//   and counts (saturating) ticks lost while a previous pulse is unaccepted.
//
// Optional feature macro: FLOW_TICK_PHASE_EN
//   defined   : i_phase port present, first pulse (period-phase) ms after enable
//   undefined : no i_phase port, every channel loads 0 at enable
//
// Ports
//   i_tick_clk    clock
//   i_tick_rst_n  asynchronous reset, active low
//   i_ch_en       per-channel run enable (level)
//   i_period      per-channel period in ms, channel c = [c*PERIOD_W +: PERIOD_W]
//   i_phase       per-channel first-pulse phase in ms (FLOW_TICK_PHASE_EN only)
//   o_tick_valid  per-channel pulse pending, held until accepted
//   i_tick_ready  per-channel consumer accept
//   i_miss_clr    per-channel missed-counter clear (1-cycle pulse)
//   o_miss_cnt    per-channel missed ticks, channel c = [c*MISS_W +: MISS_W]
// -----------------------------------------------------------------------------
module flow_tick_multi_gen #(
    parameter int    CLOCK_PERIOD = 100_000_000,
    parameter string SIM_MODE     = "TRUE",
    parameter int    CH_NUM       = 4,
    parameter int    PERIOD_W     = 16,
    parameter int    MISS_W       = 8
) (
    input  logic                       i_tick_clk,
    input  logic                       i_tick_rst_n,
    input  logic [CH_NUM-1:0]          i_ch_en,
    input  logic [CH_NUM*PERIOD_W-1:0] i_period,
`ifdef FLOW_TICK_PHASE_EN
    input  logic [CH_NUM*PERIOD_W-1:0] i_phase,
`endif
    output logic [CH_NUM-1:0]          o_tick_valid,
    input  logic [CH_NUM-1:0]          i_tick_ready,
    input  logic [CH_NUM-1:0]          i_miss_clr,
    output logic [CH_NUM*MISS_W-1:0]   o_miss_cnt
);

    localparam int MS_CNT  = (SIM_MODE == "TRUE") ? 30 : (CLOCK_PERIOD / 1000);
    localparam int PRESC_W = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MS_CNT - 1);

    logic [CH_NUM-1:0]  chEn_q;
    logic [CH_NUM-1:0]  chRise;
    logic [CH_NUM-1:0]  chFall;
    logic [CH_NUM-1:0]  chStay;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               msTick;

    assign chRise = i_ch_en & ~chEn_q;
    assign chFall = ~i_ch_en & chEn_q;
    assign chStay = i_ch_en & chEn_q;
    assign msTick = (presc_q == PRESC_LAST);

    // Shared ms prescaler. It idles at 0 while nothing runs, and restarts from
    // 0 when a channel comes up with no other channel staying enabled, so a
    // lone channel sees exactly period*MS_CNT clocks to its first pulse.
    // Channels joining a running group keep the existing ms grid untouched.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (chEn_q == '0) begin
            presc_d = '0;
        end else if ((chRise != '0) && (chStay == '0)) begin
            presc_d = '0;
        end else if (msTick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge i_tick_clk or negedge i_tick_rst_n) begin
        if (!i_tick_rst_n) begin
            chEn_q  <= '0;
            presc_q <= '0;
        end else begin
            chEn_q  <= i_ch_en;
            presc_q <= presc_d;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : gCh
        logic [PERIOD_W-1:0] cnt_q;
        logic [PERIOD_W-1:0] cnt_d;
        logic [PERIOD_W-1:0] per_q;
        logic [PERIOD_W-1:0] per_d;
        logic [PERIOD_W-1:0] perIn;
        logic [PERIOD_W-1:0] perEff;
        logic [PERIOD_W-1:0] startCnt;
        logic [MISS_W-1:0]   miss_q;
        logic [MISS_W-1:0]   miss_d;
        logic                valid_q;
        logic                valid_d;
        logic                fire;
        logic                missInc;

        assign perIn  = i_period[c*PERIOD_W +: PERIOD_W];
        // A programmed period of 0 behaves as 1 ms.
        assign perEff = (per_q == '0) ? PERIOD_W'(1) : per_q;

`ifdef FLOW_TICK_PHASE_EN
        logic [PERIOD_W-1:0] perInEff;
        logic [PERIOD_W-1:0] phaseIn;

        assign perInEff = (perIn == '0) ? PERIOD_W'(1) : perIn;
        assign phaseIn  = i_phase[c*PERIOD_W +: PERIOD_W];
        // Phase is clamped so the first pulse still needs at least one ms tick.
        assign startCnt = (phaseIn > (perInEff - PERIOD_W'(1))) ?
                          (perInEff - PERIOD_W'(1)) : phaseIn;
`else
        assign startCnt = '0;
`endif

        assign fire    = chStay[c] & msTick & (cnt_q >= (perEff - PERIOD_W'(1)));
        assign missInc = fire & valid_q & ~i_tick_ready[c];

        // ms counter and period latch; the period is only re-sampled at wrap
        // so a mid-interval change never shortens or stretches the interval.
        always_comb begin
            cnt_d = cnt_q;
            per_d = per_q;
            if (chFall[c]) begin
                cnt_d = '0;
            end else if (chRise[c]) begin
                cnt_d = startCnt;
                per_d = perIn;
            end else if (chStay[c] && msTick) begin
                if (fire) begin
                    cnt_d = '0;
                    per_d = perIn;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Pulse handshake: a fire always leaves valid high (either a fresh
        // pulse or the old one still waiting); ready only clears otherwise.
        always_comb begin
            valid_d = valid_q;
            if (chFall[c]) begin
                valid_d = 1'b0;
            end else if (fire) begin
                valid_d = 1'b1;
            end else if (i_tick_ready[c]) begin
                valid_d = 1'b0;
            end
        end

        // Saturating missed-tick counter; clear beats a same-cycle increment.
        always_comb begin
            miss_d = miss_q;
            if (i_miss_clr[c]) begin
                miss_d = '0;
            end else if (missInc && (miss_q != '1)) begin
                miss_d = miss_q + 1'b1;
            end
        end

        always_ff @(posedge i_tick_clk or negedge i_tick_rst_n) begin
            if (!i_tick_rst_n) begin
                cnt_q   <= '0;
                per_q   <= PERIOD_W'(1);
                valid_q <= 1'b0;
                miss_q  <= '0;
            end else begin
                cnt_q   <= cnt_d;
                per_q   <= per_d;
                valid_q <= valid_d;
                miss_q  <= miss_d;
            end
        end

        assign o_tick_valid[c]               = valid_q;
        assign o_miss_cnt[c*MISS_W +: MISS_W] = miss_q;
    end

endmodule
